control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter IR_WIDTH, default 32: width of the IR input.
REQ-002 Parameter OPC_LSB, default 27: low bit of the 5-bit opcode field IR[OPC_LSB+4:OPC_LSB].
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum consecutive wait cycles per memory access.
REQ-004 Clock  in  1  rising-edge clock.
REQ-005 Clear  in  1  synchronous reset, active-low.
REQ-006 IR  in  IR_WIDTH  current instruction register contents.
REQ-007 CON  in  1  branch condition flag from CON FF.
REQ-008 Mem_ready  in  1  memory access complete this cycle.
REQ-009 PCout, ZLowout, MDRout, BAout, Cout, R_out  out  1 each  bus drive enables.
REQ-010 MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, PC_enable, R_in, CON_enable  out  1 each  register load enables.
REQ-011 IncPC, MDR_read, RAM_write, Gra, Grb, Grc  out  1 each  PC increment, MDR mux select, memory write, register-field selects.
REQ-012 ALU_op  out  5  ALU operation code.
REQ-013 Run  out  1  high while sequencing.
REQ-014 Illegal  out  1  one-cycle pulse on an undefined opcode.
REQ-015 Mem_error  out  1  sticky; memory timeout occurred.

Function
REQ-016 States: RST, T0-T7, HALT; one state per cycle except memory waits.
REQ-017 Any output not listed for a state SHALL be 0; ALU_op defaults to 00011 (add).
REQ-018 Fetch: T0 PCout, MAR_enable, IncPC, ZLowIn; T1 ZLowout, PC_enable, MDR_read, MDR_enable; T2 MDRout, IR_enable.
REQ-019 T1 SHALL hold until Mem_ready=1; MDR_read/MDR_enable stay asserted; PC_enable pulses only on the first T1 cycle.
REQ-020 Decode at T2->T3 from IR opcode: 00000 ld, 00001 ldi, 00010 st, 00011-01010 ALU reg, 01011 addi, 01100 andi, 01101 ori, 10010 br, 10011 jr, 10100 jal, 11010 nop, 11011 halt.
REQ-021 ALU reg: T3 Grb, R_out, Y_enable; T4 Grc, R_out, ALU_op=opcode, ZLowIn; T5 ZLowout, Gra, R_in; then T0.
REQ-022 ALU imm: as REQ-021 except T4 drives Cout instead of Grc/R_out; ALU_op = 00011/00101/00110 for addi/andi/ori.
REQ-023 ld/ldi/st: T3 Grb, BAout, Y_enable; T4 Cout, ALU_op=add, ZLowIn; T5 ldi: ZLowout, Gra, R_in, then T0; ld/st: ZLowout, MAR_enable.
REQ-024 ld: T6 MDR_read, MDR_enable, held until Mem_ready; T7 MDRout, Gra, R_in; then T0.
REQ-025 st: T6 Gra, R_out, MDR_enable; T7 RAM_write, held until Mem_ready; then T0.
REQ-026 jal: T3 Grb, R_in, PCout; T4 Gra, R_out, PC_enable; then T0.
REQ-027 jr: T3 Gra, R_out, PC_enable; then T0.
REQ-028 br: T3 Gra, R_out, CON_enable; T4 PCout, Y_enable; T5 Cout, ALU_op=add, ZLowIn; T6 ZLowout, PC_enable = CON sampled in T6; then T0.
REQ-029 nop: T2 -> T0 directly.
REQ-030 Undefined opcode: Illegal=1 for one cycle in T3; no other outputs; then T0.
REQ-031 halt: enter HALT; Run=0; all outputs 0; remain until Clear=0.
REQ-032 Wait counter counts cycles with Mem_ready=0 in a holding state; cleared on state exit; when it reaches MEM_TIMEOUT, Mem_error=1 and enter HALT next cycle.
REQ-033 Mem_ready=1 on the first cycle of a holding state SHALL give zero wait cycles.
REQ-034 Opcode decode SHALL use only IR[OPC_LSB+4:OPC_LSB]; other IR bits are ignored.

Reset
REQ-035 Clear=0 at a rising edge SHALL enter RST from any state, including mid-wait and HALT.
REQ-036 In RST all outputs SHALL be 0, and Run, Illegal and Mem_error SHALL be 0; the wait counter SHALL clear.
REQ-037 First rising edge with Clear=1 SHALL move RST -> T0; Run=1 from T0 onward.

Verification
REQ-038 Reset, then IR=32'h59080002 (addi), Mem_ready=1 -> T0..T5 in 6 cycles; T4 Cout=1, ALU_op=00011; T5 Gra=R_in=1.
REQ-039 jal opcode 10100 -> T3 Grb, R_in, PCout=1; T4 Gra, R_out, PC_enable=1; next cycle T0.
REQ-040 br with CON=0, then with CON=1 -> T6 PC_enable=0 and 1 respectively.
REQ-041 ld with Mem_ready held low 3 cycles in T6 -> T6 lasts 4 cycles; T7 MDRout, Gra, R_in=1.
REQ-042 Mem_ready held low 16 cycles in T1 with MEM_TIMEOUT=15 -> Mem_error=1, HALT, Run=0; Clear=0 -> RST, Mem_error=0.
REQ-043 Opcode 11111 -> Illegal pulses 1 cycle in T3, then T0; opcode 11011 -> HALT with Run=0 held.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a simple bus-based CPU.
// Drives fetch/decode/execute enables from a T-state FSM.
module control_sequencer #(
  parameter int IR_WIDTH    = 32,
  parameter int OPC_LSB     = 27,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                CON,
  input  logic                Mem_ready,
  output logic                PCout,
  output logic                ZLowout,
  output logic                MDRout,
  output logic                BAout,
  output logic                Cout,
  output logic                R_out,
  output logic                MAR_enable,
  output logic                MDR_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                ZLowIn,
  output logic                PC_enable,
  output logic                R_in,
  output logic                CON_enable,
  output logic                IncPC,
  output logic                MDR_read,
  output logic                RAM_write,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic [4:0]          ALU_op,
  output logic                Run,
  output logic                Illegal,
  output logic                Mem_error
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          merr_q, merr_d;

  logic [4:0] opc;
  logic       unused_ir;
  assign opc       = IR[OPC_LSB+4:OPC_LSB];
  assign unused_ir = ^IR;

  logic is_ld, is_ldi, is_st, is_alu, is_imm;
  logic is_br, is_jr, is_jal, is_nop, is_halt, legal;
  assign is_ld   = (opc == 5'd0);
  assign is_ldi  = (opc == 5'd1);
  assign is_st   = (opc == 5'd2);
  assign is_alu  = (opc >= 5'd3) && (opc <= 5'd10);
  assign is_imm  = (opc >= 5'd11) && (opc <= 5'd13);
  assign is_br   = (opc == 5'd18);
  assign is_jr   = (opc == 5'd19);
  assign is_jal  = (opc == 5'd20);
  assign is_nop  = (opc == 5'd26);
  assign is_halt = (opc == 5'd27);
  assign legal   = is_ld | is_ldi | is_st | is_alu | is_imm
                 | is_br | is_jr | is_jal | is_nop | is_halt;

  // States that wait on the memory handshake
  logic hold, timeout;
  assign hold    = (state_q == S_T1)
                 | ((state_q == S_T6) & is_ld)
                 | ((state_q == S_T7) & is_st);
  assign timeout = hold & ~Mem_ready
                 & (wcnt_q == CW'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = Mem_ready ? S_T2 : S_T1;
      S_T2: begin
        if (is_nop)       state_d = S_T0;
        else if (is_halt) state_d = S_HALT;
        else              state_d = S_T3;
      end
      S_T3:  state_d = (is_jr | ~legal) ? S_T0 : S_T4;
      S_T4:  state_d = is_jal ? S_T0 : S_T5;
      S_T5:  state_d = (is_ld | is_st | is_br) ? S_T6 : S_T0;
      S_T6: begin
        if (is_ld)      state_d = Mem_ready ? S_T7 : S_T6;
        else if (is_st) state_d = S_T7;
        else            state_d = S_T0;
      end
      S_T7: begin
        if (is_st) state_d = Mem_ready ? S_T0 : S_T7;
        else       state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    if (timeout) state_d = S_HALT;
  end

  assign wcnt_d = (hold & ~Mem_ready & ~timeout)
                ? wcnt_q + CW'(1) : '0;
  assign merr_d = merr_q | timeout;

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q <= S_RST;
      wcnt_q  <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      merr_q  <= merr_d;
    end
  end

  assign Mem_error = merr_q;

  always_comb begin
    PCout = 0; ZLowout = 0; MDRout = 0; BAout = 0;
    Cout = 0; R_out = 0; MAR_enable = 0; MDR_enable = 0;
    IR_enable = 0; Y_enable = 0; ZLowIn = 0; PC_enable = 0;
    R_in = 0; CON_enable = 0; IncPC = 0; MDR_read = 0;
    RAM_write = 0; Gra = 0; Grb = 0; Grc = 0;
    ALU_op = 5'b00011; Illegal = 0;
    Run = (state_q != S_RST) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        PCout = 1; MAR_enable = 1; IncPC = 1; ZLowIn = 1;
      end
      S_T1: begin
        ZLowout = 1; MDR_read = 1; MDR_enable = 1;
        PC_enable = (wcnt_q == '0);
      end
      S_T2: begin
        MDRout = 1; IR_enable = 1;
      end
      S_T3: begin
        if (is_alu | is_imm) begin
          Grb = 1; R_out = 1; Y_enable = 1;
        end else if (is_ld | is_ldi | is_st) begin
          Grb = 1; BAout = 1; Y_enable = 1;
        end else if (is_jal) begin
          Grb = 1; R_in = 1; PCout = 1;
        end else if (is_jr) begin
          Gra = 1; R_out = 1; PC_enable = 1;
        end else if (is_br) begin
          Gra = 1; R_out = 1; CON_enable = 1;
        end else if (!legal) begin
          Illegal = 1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          Grc = 1; R_out = 1; ZLowIn = 1; ALU_op = opc;
        end else if (is_imm) begin
          Cout = 1; ZLowIn = 1;
          ALU_op = (opc == 5'd12) ? 5'b00101 :
                   (opc == 5'd13) ? 5'b00110 : 5'b00011;
        end else if (is_ld | is_ldi | is_st) begin
          Cout = 1; ZLowIn = 1;
        end else if (is_jal) begin
          Gra = 1; R_out = 1; PC_enable = 1;
        end else if (is_br) begin
          PCout = 1; Y_enable = 1;
        end
      end
      S_T5: begin
        if (is_alu | is_imm | is_ldi) begin
          ZLowout = 1; Gra = 1; R_in = 1;
        end else if (is_ld | is_st) begin
          ZLowout = 1; MAR_enable = 1;
        end else if (is_br) begin
          Cout = 1; ZLowIn = 1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          MDR_read = 1; MDR_enable = 1;
        end else if (is_st) begin
          Gra = 1; R_out = 1; MDR_enable = 1;
        end else if (is_br) begin
          ZLowout = 1; PC_enable = CON;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1; Gra = 1; R_in = 1;
        end else if (is_st) begin
          RAM_write = 1;
        end
      end
      default: ALU_op = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Vector/scoreboard bench for control_sequencer.
// Expected output words are queued at drive time and checked at negedge.
module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Clear = 1'b0;
  logic [31:0] IR = '0;
  logic        CON = 1'b0;
  logic        Mem_ready = 1'b1;
  logic PCout, ZLowout, MDRout, BAout, Cout, R_out;
  logic MAR_enable, MDR_enable, IR_enable, Y_enable;
  logic ZLowIn, PC_enable, R_in, CON_enable;
  logic IncPC, MDR_read, RAM_write, Gra, Grb, Grc;
  logic [4:0] ALU_op;
  logic Run, Illegal, Mem_error;

  control_sequencer dut (
    .Clock(clk), .Clear(Clear), .IR(IR), .CON(CON),
    .Mem_ready(Mem_ready),
    .PCout(PCout), .ZLowout(ZLowout), .MDRout(MDRout),
    .BAout(BAout), .Cout(Cout), .R_out(R_out),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable),
    .ZLowIn(ZLowIn), .PC_enable(PC_enable), .R_in(R_in),
    .CON_enable(CON_enable), .IncPC(IncPC),
    .MDR_read(MDR_read), .RAM_write(RAM_write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALU_op(ALU_op),
    .Run(Run), .Illegal(Illegal), .Mem_error(Mem_error)
  );

  logic [27:0] got;
  assign got = {PCout, ZLowout, MDRout, BAout, Cout, R_out,
                MAR_enable, MDR_enable, IR_enable, Y_enable,
                ZLowIn, PC_enable, R_in, CON_enable,
                IncPC, MDR_read, RAM_write, Gra, Grb, Grc,
                ALU_op, Run, Illegal, Mem_error};

  localparam logic [27:0] B_PCOUT = 28'd1 << 27;
  localparam logic [27:0] B_ZOUT  = 28'd1 << 26;
  localparam logic [27:0] B_MDROUT= 28'd1 << 25;
  localparam logic [27:0] B_BAOUT = 28'd1 << 24;
  localparam logic [27:0] B_COUT  = 28'd1 << 23;
  localparam logic [27:0] B_ROUT  = 28'd1 << 22;
  localparam logic [27:0] B_MAR   = 28'd1 << 21;
  localparam logic [27:0] B_MDREN = 28'd1 << 20;
  localparam logic [27:0] B_IREN  = 28'd1 << 19;
  localparam logic [27:0] B_YEN   = 28'd1 << 18;
  localparam logic [27:0] B_ZIN   = 28'd1 << 17;
  localparam logic [27:0] B_PCEN  = 28'd1 << 16;
  localparam logic [27:0] B_RIN   = 28'd1 << 15;
  localparam logic [27:0] B_CONEN = 28'd1 << 14;
  localparam logic [27:0] B_INCPC = 28'd1 << 13;
  localparam logic [27:0] B_MDRRD = 28'd1 << 12;
  localparam logic [27:0] B_RAMW  = 28'd1 << 11;
  localparam logic [27:0] B_GRA   = 28'd1 << 10;
  localparam logic [27:0] B_GRB   = 28'd1 << 9;
  localparam logic [27:0] B_GRC   = 28'd1 << 8;
  localparam logic [27:0] B_ILL   = 28'd1 << 1;
  localparam logic [27:0] B_MERR  = 28'd1 << 0;

  function automatic logic [27:0] e(input logic [27:0] m,
                                    input logic [4:0] alu = 5'd3,
                                    input logic run = 1'b1);
    return m | (28'(alu) << 3) | (28'(run) << 2);
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] opc);
    return {opc, 27'h2d3c1b7};
  endfunction

  typedef struct {
    string       nm;
    logic        clr;
    logic [31:0] ir;
    logic        con;
    logic        mr;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic clr,
                     input logic [31:0] ir, input logic con,
                     input logic mr, input logic [27:0] exp);
    vec_t v;
    v.nm = nm; v.clr = clr; v.ir = ir;
    v.con = con; v.mr = mr; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic fetch(input string nm, input logic [31:0] ir,
                       input logic con);
    add({nm, "_t0"}, 1, ir, con, 1,
        e(B_PCOUT | B_MAR | B_INCPC | B_ZIN));
    add({nm, "_t1"}, 1, ir, con, 1,
        e(B_ZOUT | B_PCEN | B_MDRRD | B_MDREN));
    add({nm, "_t2"}, 1, ir, con, 1, e(B_MDROUT | B_IREN));
  endtask

  logic [27:0] expq[$];
  string       nmq[$];
  int nvec = 0;
  int nerr = 0;

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [27:0] x;
      string n;
      x = expq.pop_front();
      n = nmq.pop_front();
      nvec++;
      if (got !== x) begin
        nerr++;
        $display("FAIL %s: got %h want %h", n, got, x);
      end
    end
  end

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    Clear = v.clr; IR = v.ir; CON = v.con; Mem_ready = v.mr;
    expq.push_back(v.exp);
    nmq.push_back(v.nm);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  localparam logic [27:0] T3_ALU = B_GRB | B_ROUT | B_YEN;
  localparam logic [27:0] T3_MEM = B_GRB | B_BAOUT | B_YEN;
  localparam logic [27:0] T5_WB  = B_ZOUT | B_GRA | B_RIN;

  initial begin
    logic [31:0] ir;
    repeat (2) @(posedge clk);

    // reset and release
    add("rst", 0, 32'h0, 0, 1, e(0, 5'd0, 0));
    add("rst_rel", 1, 32'h0, 0, 1, e(0, 5'd0, 0));

    ir = 32'h59080002;
    fetch("addi", ir, 0);
    add("addi_t3", 1, ir, 0, 1, e(T3_ALU));
    add("addi_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN, 5'b00011));
    add("addi_t5", 1, ir, 0, 1, e(T5_WB));

    ir = mk(5'b00111);
    fetch("alu", ir, 0);
    add("alu_t3", 1, ir, 0, 1, e(T3_ALU));
    add("alu_t4", 1, ir, 0, 1,
        e(B_GRC | B_ROUT | B_ZIN, 5'b00111));
    add("alu_t5", 1, ir, 0, 1, e(T5_WB));

    ir = mk(5'b01100);
    fetch("andi", ir, 0);
    add("andi_t3", 1, ir, 0, 1, e(T3_ALU));
    add("andi_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN, 5'b00101));
    add("andi_t5", 1, ir, 0, 1, e(T5_WB));

    ir = mk(5'b01101);
    fetch("ori", ir, 0);
    add("ori_t3", 1, ir, 0, 1, e(T3_ALU));
    add("ori_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN, 5'b00110));
    add("ori_t5", 1, ir, 0, 1, e(T5_WB));

    ir = mk(5'b10100);
    fetch("jal", ir, 0);
    add("jal_t3", 1, ir, 0, 1, e(B_GRB | B_RIN | B_PCOUT));
    add("jal_t4", 1, ir, 0, 1, e(B_GRA | B_ROUT | B_PCEN));

    for (int c = 0; c < 2; c++) begin
      ir = mk(5'b10010);
      fetch("br", ir, c[0]);
      add("br_t3", 1, ir, c[0], 1,
          e(B_GRA | B_ROUT | B_CONEN));
      add("br_t4", 1, ir, c[0], 1, e(B_PCOUT | B_YEN));
      add("br_t5", 1, ir, c[0], 1, e(B_COUT | B_ZIN));
      add(c[0] ? "br_t6_con1" : "br_t6_con0", 1, ir, c[0], 1,
          e(B_ZOUT | (c[0] ? B_PCEN : 28'd0)));
    end

    ir = mk(5'b10011);
    fetch("jr", ir, 0);
    add("jr_t3", 1, ir, 0, 1, e(B_GRA | B_ROUT | B_PCEN));

    ir = mk(5'b00001);
    fetch("ldi", ir, 0);
    add("ldi_t3", 1, ir, 0, 1, e(T3_MEM));
    add("ldi_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN));
    add("ldi_t5", 1, ir, 0, 1, e(T5_WB));

    ir = mk(5'b00000);
    fetch("ld", ir, 0);
    add("ld_t3", 1, ir, 0, 1, e(T3_MEM));
    add("ld_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN));
    add("ld_t5", 1, ir, 0, 1, e(B_ZOUT | B_MAR));
    for (int k = 0; k < 4; k++)
      add("ld_t6", 1, ir, 0, (k == 3), e(B_MDRRD | B_MDREN));
    add("ld_t7", 1, ir, 0, 1, e(B_MDROUT | B_GRA | B_RIN));

    ir = mk(5'b00010);
    fetch("st", ir, 0);
    add("st_t3", 1, ir, 0, 1, e(T3_MEM));
    add("st_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN));
    add("st_t5", 1, ir, 0, 1, e(B_ZOUT | B_MAR));
    add("st_t6", 1, ir, 0, 1, e(B_GRA | B_ROUT | B_MDREN));
    add("st_t7w", 1, ir, 0, 0, e(B_RAMW));
    add("st_t7", 1, ir, 0, 1, e(B_RAMW));

    fetch("nop", mk(5'b11010), 0);

    ir = mk(5'b11111);
    fetch("ill", ir, 0);
    add("ill_t3", 1, ir, 0, 1, e(B_ILL));
    run_tbl();

    // fetch wait: PC_enable only on the first T1 cycle
    ir = 32'h59080002;
    add("fw_t0", 1, ir, 0, 1, e(B_PCOUT | B_MAR | B_INCPC | B_ZIN));
    add("fw_t1a", 1, ir, 0, 0, e(B_ZOUT | B_PCEN | B_MDRRD | B_MDREN));
    add("fw_t1b", 1, ir, 0, 0, e(B_ZOUT | B_MDRRD | B_MDREN));
    add("fw_t1c", 1, ir, 0, 1, e(B_ZOUT | B_MDRRD | B_MDREN));
    add("fw_t2", 1, ir, 0, 1, e(B_MDROUT | B_IREN));
    add("fw_t3", 1, ir, 0, 1, e(T3_ALU));
    add("fw_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN));
    add("fw_t5", 1, ir, 0, 1, e(T5_WB));
    run_tbl();

    // reset in the middle of a load wait
    ir = mk(5'b00000);
    fetch("ldr", ir, 0);
    add("ldr_t3", 1, ir, 0, 1, e(T3_MEM));
    add("ldr_t4", 1, ir, 0, 1, e(B_COUT | B_ZIN));
    add("ldr_t5", 1, ir, 0, 1, e(B_ZOUT | B_MAR));
    add("ldr_t6", 1, ir, 0, 0, e(B_MDRRD | B_MDREN));
    add("ldr_t6c", 0, ir, 0, 0, e(B_MDRRD | B_MDREN));
    add("ldr_rst", 1, ir, 0, 0, e(0, 5'd0, 0));
    run_tbl();

    // memory timeout in T1: 16 low cycles, then HALT with Mem_error
    ir = 32'h59080002;
    add("to_t0", 1, ir, 0, 0, e(B_PCOUT | B_MAR | B_INCPC | B_ZIN));
    add("to_t1", 1, ir, 0, 0, e(B_ZOUT | B_PCEN | B_MDRRD | B_MDREN));
    for (int k = 0; k < 15; k++)
      add("to_t1w", 1, ir, 0, 0, e(B_ZOUT | B_MDRRD | B_MDREN));
    for (int k = 0; k < 3; k++)
      add("to_halt", 1, ir, 0, 1, e(B_MERR, 5'd0, 0));
    add("to_halt_clr", 0, ir, 0, 1, e(B_MERR, 5'd0, 0));
    add("to_rst", 1, ir, 0, 1, e(0, 5'd0, 0));
    run_tbl();

    // halt opcode: stays halted until Clear
    ir = mk(5'b11011);
    fetch("halt", ir, 0);
    for (int k = 0; k < 4; k++)
      add("halt_hold", 1, ir, 0, 1, e(0, 5'd0, 0));
    add("halt_clr", 0, ir, 0, 1, e(0, 5'd0, 0));
    add("halt_rst", 1, ir, 0, 1, e(0, 5'd0, 0));
    add("halt_t0", 1, ir, 0, 1, e(B_PCOUT | B_MAR | B_INCPC | B_ZIN));
    run_tbl();

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
